// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: widths, opcodes, states.
// Imported by alu_cmd_sequencer and alu_op_check.
package alu_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
   localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
   localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
   localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
   localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
   localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
   localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
   localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

   typedef enum logic [3:0] {
      RX_A,
      RX_B,
      RX_OP,
      LD_A,
      LD_B,
      LD_OP,
      WAIT,
      TX_RES,
      TX_FLG
   } state_t;

endpackage

// File: rtl/alu_op_check.sv
// Opcode legality decoder: high when the opcode is one the ALU implements.
// Only instantiated when ALU_SEQ_OP_CHECK_EN is defined.
module alu_op_check
   import alu_pkg::*;
#(
   parameter int NB_OP = NB_OP_DEF
) (
   input  logic [NB_OP-1:0] i_op,
   output logic             o_valid
);

   // Match against the eight supported opcodes.
   always_comb begin
      o_valid = 1'b0;
      unique case (i_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: o_valid = 1'b1;
         default:                        o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream front end for the ALU register top: A, B, opcode in; result, flags out.
// Define ALU_SEQ_OP_CHECK_EN to reject unknown opcodes with a 0x00/0x80 response.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_OP   = NB_OP_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_rx_ready,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op,
   output logic               o_en_A,
   output logic               o_en_B,
   output logic               o_en_OP,
   input  logic [NB_DATA-1:0] i_result,
   input  logic               i_zero,
   input  logic               i_overflow,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy
);

   localparam logic [NB_DATA-1:0] BAD_FLG =
      {1'b1, {(NB_DATA-1){1'b0}}};

   state_t             state;
   logic [NB_DATA-1:0] a_buf;
   logic [NB_DATA-1:0] b_buf;
   logic [NB_OP-1:0]   op_buf;
   logic [NB_DATA-1:0] flg_buf;
   logic               op_ok;
   logic               rx_state;

`ifdef ALU_SEQ_OP_CHECK_EN
   alu_op_check #(
      .NB_OP (NB_OP)
   ) u_op_check (
      .i_op    (i_rx_data[NB_OP-1:0]),
      .o_valid (op_ok)
   );
`else
   assign op_ok = 1'b1;
`endif

   assign rx_state = (state == RX_A) ||
                     (state == RX_B) ||
                     (state == RX_OP);

   // Ready is gated by reset so nothing is accepted while it is held.
   assign o_rx_ready = rx_state && !i_rst;
   assign o_busy     = (state != RX_A);

   // Command FSM; strobes and buses change on the edge entering each state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= RX_A;
         a_buf      <= '0;
         b_buf      <= '0;
         op_buf     <= '0;
         flg_buf    <= '0;
         o_data_a   <= '0;
         o_data_b   <= '0;
         o_op       <= '0;
         o_en_A     <= 1'b0;
         o_en_B     <= 1'b0;
         o_en_OP    <= 1'b0;
         o_tx_data  <= '0;
         o_tx_valid <= 1'b0;
      end else begin
         unique case (state)
            RX_A: begin
               if (i_rx_valid) begin
                  a_buf <= i_rx_data;
                  state <= RX_B;
               end
            end
            RX_B: begin
               if (i_rx_valid) begin
                  b_buf <= i_rx_data;
                  state <= RX_OP;
               end
            end
            RX_OP: begin
               if (i_rx_valid) begin
                  op_buf <= i_rx_data[NB_OP-1:0];
                  if (op_ok) begin
                     o_data_a <= a_buf;
                     o_en_A   <= 1'b1;
                     state    <= LD_A;
                  end else begin
                     o_tx_data  <= '0;
                     o_tx_valid <= 1'b1;
                     flg_buf    <= BAD_FLG;
                     state      <= TX_RES;
                  end
               end
            end
            LD_A: begin
               o_en_A   <= 1'b0;
               o_data_b <= b_buf;
               o_en_B   <= 1'b1;
               state    <= LD_B;
            end
            LD_B: begin
               o_en_B  <= 1'b0;
               o_op    <= op_buf;
               o_en_OP <= 1'b1;
               state   <= LD_OP;
            end
            LD_OP: begin
               o_en_OP <= 1'b0;
               state   <= WAIT;
            end
            WAIT: begin
               o_tx_data  <= i_result;
               o_tx_valid <= 1'b1;
               flg_buf    <= {{(NB_DATA-2){1'b0}},
                              i_overflow, i_zero};
               state      <= TX_RES;
            end
            TX_RES: begin
               if (i_tx_ready) begin
                  o_tx_data <= flg_buf;
                  state     <= TX_FLG;
               end
            end
            TX_FLG: begin
               if (i_tx_ready) begin
                  o_tx_valid <= 1'b0;
                  o_tx_data  <= '0;
                  state      <= RX_A;
               end
            end
            default: state <= RX_A;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU register top.
// Build with ALU_SEQ_OP_CHECK_EN defined to exercise the opcode-reject path.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic [7:0] i_rx_data = '0;
   logic       i_rx_valid = 1'b0;
   logic       o_rx_ready;
   logic [7:0] o_data_a;
   logic [7:0] o_data_b;
   logic [5:0] o_op;
   logic       o_en_A;
   logic       o_en_B;
   logic       o_en_OP;
   logic [7:0] i_result;
   logic       i_zero;
   logic       i_overflow;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic       i_tx_ready = 1'b0;
   logic       o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   alu_cmd_sequencer #(
      .NB_DATA (8),
      .NB_OP   (6)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_rx_data  (i_rx_data),
      .i_rx_valid (i_rx_valid),
      .o_rx_ready (o_rx_ready),
      .o_data_a   (o_data_a),
      .o_data_b   (o_data_b),
      .o_op       (o_op),
      .o_en_A     (o_en_A),
      .o_en_B     (o_en_B),
      .o_en_OP    (o_en_OP),
      .i_result   (i_result),
      .i_zero     (i_zero),
      .i_overflow (i_overflow),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_ready (i_tx_ready),
      .o_busy     (o_busy)
   );

   // ALU register top: latch on strobes, carry/borrow reported as overflow.
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic [8:0] alu_w;

   always @(posedge i_clk) begin
      if (o_en_A)  alu_a  <= o_data_a;
      if (o_en_B)  alu_b  <= o_data_b;
      if (o_en_OP) alu_op <= o_op;
   end

   always_comb begin
      alu_w = 9'h05A;
      case (alu_op)
         OP_ADD: alu_w = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SUB: alu_w = {1'b0, alu_a} - {1'b0, alu_b};
         OP_AND: alu_w = {1'b0, alu_a & alu_b};
         OP_OR:  alu_w = {1'b0, alu_a | alu_b};
         OP_XOR: alu_w = {1'b0, alu_a ^ alu_b};
         OP_NOR: alu_w = {1'b0, ~(alu_a | alu_b)};
         OP_SRA: alu_w = {1'b0, 8'($signed(alu_a) >>> alu_b[2:0])};
         OP_SRL: alu_w = {1'b0, alu_a >> alu_b[2:0]};
         default: alu_w = 9'h05A;
      endcase
   end

   assign i_result   = alu_w[7:0];
   assign i_overflow = alu_w[8];
   assign i_zero     = (alu_w[7:0] == 8'h00);

   // Strobe monitor: pulse counts, last pulse time, bus value, overlaps.
   int         n_a = 0;
   int         n_b = 0;
   int         n_op = 0;
   int         n_ovl = 0;
   time        t_a, t_b, t_op;
   logic [7:0] seen_a, seen_b;
   logic [5:0] seen_op;

   always @(negedge i_clk) begin
      if (o_en_A) begin
         n_a++; t_a = $time; seen_a = o_data_a;
      end
      if (o_en_B) begin
         n_b++; t_b = $time; seen_b = o_data_b;
      end
      if (o_en_OP) begin
         n_op++; t_op = $time; seen_op = o_op;
      end
      if ((int'(o_en_A) + int'(o_en_B) + int'(o_en_OP)) > 1)
         n_ovl++;
   end

   task automatic check_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k;
      k = 0;
      @(negedge i_clk);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      while (!o_rx_ready && k < 100) begin
         @(negedge i_clk);
         k++;
      end
      if (k >= 100) check_eq("rx_timeout", k, 0);
      @(posedge i_clk);
      #1;
      i_rx_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] a,
                           input logic [7:0] b,
                           input logic [7:0] op);
      send_byte(a);
      send_byte(b);
      send_byte(op);
   endtask

   // k = index of the first rising edge at which o_tx_valid is high.
   task automatic wait_tx(output int k);
      k = 0;
      do begin
         @(negedge i_clk);
         k++;
      end while (!o_tx_valid && k < 100);
      if (k >= 100) check_eq("tx_timeout", k, 0);
   endtask

   task automatic take_tx(input string tag, input logic [7:0] exp);
      check_eq(tag, o_tx_data, exp);
      i_tx_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_tx_ready = 1'b0;
   endtask

   task automatic get_resp(input string tag,
                           input logic [7:0] er,
                           input logic [7:0] ef,
                           input bit chk_lat);
      int k;
      wait_tx(k);
      if (chk_lat) check_eq({tag, "_lat"}, k, 5);
      take_tx({tag, "_res"}, er);
      wait_tx(k);
      take_tx({tag, "_flg"}, ef);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a0, b0, op0, k;

      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      check_eq("rst_ready", o_rx_ready, 0);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_txv", o_tx_valid, 0);
      check_eq("rst_strobes", {o_en_A, o_en_B, o_en_OP}, 0);
      check_eq("rst_txd", o_tx_data, 0);
      i_rst = 1'b0;
      #1;
      check_eq("rel_ready", o_rx_ready, 1);

      // ADD 5 + 3
      a0 = n_a; b0 = n_b; op0 = n_op;
      send_cmd(8'h05, 8'h03, 8'h20);
      check_eq("add_busy", o_busy, 1);
      get_resp("add", 8'h08, 8'h00, 1'b1);
      check_eq("add_ready_after", o_rx_ready, 1);
      check_eq("add_na", n_a - a0, 1);
      check_eq("add_nb", n_b - b0, 1);
      check_eq("add_nop", n_op - op0, 1);
      check_eq("add_order", (t_a < t_b) && (t_b < t_op), 1);
      check_eq("add_bus_a", seen_a, 8'h05);
      check_eq("add_bus_b", seen_b, 8'h03);
      check_eq("add_bus_op", seen_op, 6'h20);
      check_eq("hold_a", o_data_a, 8'h05);

      // ADD wrap to zero with carry
      send_cmd(8'hFF, 8'h01, 8'h20);
      get_resp("wrap", 8'h00, 8'h03, 1'b1);

      // SUB with borrow
      send_cmd(8'h03, 8'h05, 8'h22);
      get_resp("sub", 8'hFE, 8'h02, 1'b1);

      // Backpressure, with stray rx traffic while busy
      send_cmd(8'h05, 8'h03, 8'h20);
      i_rx_data  = 8'h77;
      i_rx_valid = 1'b1;
      wait_tx(k);
      check_eq("bp_lat", k, 5);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", o_tx_valid, 1);
         check_eq("bp_data", o_tx_data, 8'h08);
         @(negedge i_clk);
      end
      take_tx("bp_res", 8'h08);
      i_rx_valid = 1'b0;
      wait_tx(k);
      take_tx("bp_flg", 8'h00);

      // Opcode upper bits ignored
      send_cmd(8'h02, 8'h02, 8'hE0);
      get_resp("hi", 8'h04, 8'h00, 1'b1);
      check_eq("hi_op", seen_op, 6'h20);
      check_eq("overlap", n_ovl, 0);

      // Reset during LD_B
      send_cmd(8'h09, 8'h02, 8'h20);
      k = 0;
      do begin
         @(negedge i_clk);
         k++;
      end while (!o_en_B && k < 20);
      check_eq("ldb_seen", o_en_B, 1);
      i_rst = 1'b1;
      #1;
      check_eq("ldb_rst_strobes", {o_en_A, o_en_B, o_en_OP}, 0);
      check_eq("ldb_rst_txv", o_tx_valid, 0);
      check_eq("ldb_rst_ready", o_rx_ready, 0);
      check_eq("ldb_rst_datab", o_data_b, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check_eq("ldb_rel_ready", o_rx_ready, 1);

      // Partial command discarded by reset
      send_byte(8'h44);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      send_cmd(8'h01, 8'h01, 8'h24);
      get_resp("and", 8'h01, 8'h00, 1'b1);

      // Unsupported opcode 0x3F
      a0 = n_a; b0 = n_b; op0 = n_op;
      send_cmd(8'h22, 8'h11, 8'h3F);
`ifdef ALU_SEQ_OP_CHECK_EN
      get_resp("bad", 8'h00, 8'h80, 1'b0);
      check_eq("bad_na", n_a - a0, 0);
      check_eq("bad_nb", n_b - b0, 0);
      check_eq("bad_nop", n_op - op0, 0);
`else
      get_resp("bad", 8'h5A, 8'h00, 1'b1);
      check_eq("bad_nop", n_op - op0, 1);
      check_eq("bad_op", seen_op, 6'h3F);
`endif
      check_eq("overlap_end", n_ovl, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
